// File: rtl/vplex_palette_out_pkg.sv
// Shared video-plex constants: CRAM geometry, RGB555 field positions and the
// pixel index width agreed with the renderer.
package vplex_palette_out_pkg;

  localparam int CRAM_AW   = 8;
  localparam int CRAM_DW   = 16;
  localparam int PIX_IDX_W = 8;
  localparam int NIB_W     = 4;
  localparam int RGB_W     = 15;

  localparam int R_MSB = 14;
  localparam int R_LSB = 10;
  localparam int G_MSB = 9;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Blanked slots still produce a pixel, just black.
  function automatic logic [RGB_W-1:0] rgb_gate(input logic blank_i,
                                                input logic [RGB_W-1:0] rgb_i);
    return blank_i ? '0 : rgb_i;
  endfunction

endpackage

// File: rtl/vplex_palette_out_cram_dp256x16.sv
// Colour RAM: one synchronous write port, one registered read port, no reset.
// A same-address read/write returns the old word; the caller adds any bypass.
module cram_dp256x16 #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vplex_palette_out.sv
// Palette output stage: unpacks lo/hi-res pixel indices, looks them up in CRAM
// and presents registered RGB555 three clocks after each accepted strobe.
module vplex_palette_out
  import vplex_palette_out_pkg::*;
#(
  parameter int CRAM_AW = vplex_palette_out_pkg::CRAM_AW,
  parameter int CRAM_DW = vplex_palette_out_pkg::CRAM_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               hpix_en,
  input  logic [7:0]         vplex_in,
  input  logic               hires,
  input  logic [3:0]         palsel,
  input  logic               blank,
  input  logic               cram_we,
  input  logic [CRAM_AW-1:0] cram_addr,
  input  logic [CRAM_DW-1:0] cram_data,
  output logic [4:0]         vred,
  output logic [4:0]         vgrn,
  output logic [4:0]         vblu,
  output logic               vvalid
);

  logic [CRAM_AW-1:0] idx_q, idx_d;
  logic [NIB_W-1:0]   nib_hold_q, nib_hold_d;
  logic [NIB_W-1:0]   pal_hold_q, pal_hold_d;
  logic               hr_pend_q, hr_pend_d;
  logic               blank_s0_q, blank_s0_d;
  logic               v_s0_q, v_s0_d;
  logic               blank_s1_q, v_s1_q;
  logic               byp_q;
  logic [CRAM_DW-1:0] byp_data_q;
  logic [CRAM_DW-1:0] ram_rdata;
  logic [CRAM_DW-1:0] s1_data;
  logic [RGB_W-1:0]   rgb_q;
  logic               vvalid_q;
  logic               unused_rsvd;

  // A new lo-res slot always wins; the held half is only used by hpix_en.
  always_comb begin
    idx_d      = idx_q;
    nib_hold_d = nib_hold_q;
    pal_hold_d = pal_hold_q;
    hr_pend_d  = hr_pend_q;
    blank_s0_d = blank_s0_q;
    v_s0_d     = 1'b0;
    if (pix_en) begin
      v_s0_d     = 1'b1;
      blank_s0_d = blank;
      if (hires) begin
        idx_d      = {palsel, vplex_in[7:4]};
        nib_hold_d = vplex_in[3:0];
        pal_hold_d = palsel;
        hr_pend_d  = 1'b1;
      end else begin
        idx_d     = vplex_in;
        hr_pend_d = 1'b0;
      end
    end else if (hpix_en && hr_pend_q) begin
      v_s0_d     = 1'b1;
      blank_s0_d = blank;
      idx_d      = {pal_hold_q, nib_hold_q};
      hr_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      hr_pend_q  <= 1'b0;
      blank_s0_q <= 1'b1;
      v_s0_q     <= 1'b0;
      blank_s1_q <= 1'b1;
      v_s1_q     <= 1'b0;
      byp_q      <= 1'b0;
      rgb_q      <= '0;
      vvalid_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      hr_pend_q  <= hr_pend_d;
      blank_s0_q <= blank_s0_d;
      v_s0_q     <= v_s0_d;
      blank_s1_q <= blank_s0_q;
      v_s1_q     <= v_s0_q;
      byp_q      <= cram_we && (cram_addr == idx_q);
      if (v_s1_q) begin
        rgb_q <= rgb_gate(blank_s1_q, s1_data[R_MSB:B_LSB]);
      end
      vvalid_q <= v_s1_q;
    end
  end

  // Held nibble/palette and bypass word need no reset: always qualified.
  always_ff @(posedge clk) begin
    nib_hold_q <= nib_hold_d;
    pal_hold_q <= pal_hold_d;
    byp_data_q <= cram_data;
  end

  cram_dp256x16 #(
    .AW (CRAM_AW),
    .DW (CRAM_DW)
  ) u_cram (
    .clk       (clk),
    .wr_en_i   (cram_we),
    .wr_addr_i (cram_addr),
    .wr_data_i (cram_data),
    .rd_addr_i (idx_q),
    .rd_data_o (ram_rdata)
  );

  // A write landing on the same clock as the lookup wins over the stale read.
  assign s1_data     = byp_q ? byp_data_q : ram_rdata;
  assign unused_rsvd = s1_data[CRAM_DW-1];

  assign vred   = rgb_q[R_MSB:R_LSB];
  assign vgrn   = rgb_q[G_MSB:G_LSB];
  assign vblu   = rgb_q[B_MSB:B_LSB];
  assign vvalid = vvalid_q;

endmodule

// File: tb/tb_vplex_palette_out.sv
// Directed bench for vplex_palette_out: lo/hi-res lookup, bypass, blanking,
// orphan/override strobes and reset mid-pair, with hand-computed colours.
module tb_vplex_palette_out;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic        hpix_en;
  logic [7:0]  vplex_in;
  logic        hires;
  logic [3:0]  palsel;
  logic        blank;
  logic        cram_we;
  logic [7:0]  cram_addr;
  logic [15:0] cram_data;
  logic [4:0]  vred;
  logic [4:0]  vgrn;
  logic [4:0]  vblu;
  logic        vvalid;

  int n_cmp = 0;
  int n_err = 0;

  vplex_palette_out dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hpix_en   (hpix_en),
    .vplex_in  (vplex_in),
    .hires     (hires),
    .palsel    (palsel),
    .blank     (blank),
    .cram_we   (cram_we),
    .cram_addr (cram_addr),
    .cram_data (cram_data),
    .vred      (vred),
    .vgrn      (vgrn),
    .vblu      (vblu),
    .vvalid    (vvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_px(input string tag, input logic v,
                        input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    logic [15:0] obs;
    logic [15:0] exp;
    obs = {vvalid, vred, vgrn, vblu};
    exp = {v, r, g, b};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed {v,r,g,b}=%h required %h", tag, obs, exp);
    end
    $display("check %-14s v=%0d r=%h g=%h b=%h", tag, vvalid, vred, vgrn, vblu);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cram_we   = 1'b1;
    cram_addr = a;
    cram_data = d;
    step();
    cram_we = 1'b0;
  endtask

  task automatic strobe_lo(input logic [7:0] v, input logic b);
    pix_en   = 1'b1;
    hires    = 1'b0;
    vplex_in = v;
    blank    = b;
    step();
    pix_en = 1'b0;
    blank  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hpix_en = 1'b0; vplex_in = 8'h00;
    hires = 1'b0; palsel = 4'h0; blank = 1'b0;
    cram_we = 1'b0; cram_addr = 8'h00; cram_data = 16'h0000;

    // Reset state
    step(); step(); step();
    chk_px("reset", 1'b0, 5'h00, 5'h00, 5'h00);
    rst = 1'b0;

    // CRAM preload
    wr(8'h5A, 16'h7C1F);
    wr(8'h3A, 16'h7C00);
    wr(8'h35, 16'h03E0);
    wr(8'h37, 16'h0001);
    wr(8'h10, 16'h0000);
    wr(8'h77, 16'h7FFF);
    chk_px("idle", 1'b0, 5'h00, 5'h00, 5'h00);

    // Lo-res lookup and three-clock latency
    strobe_lo(8'h5A, 1'b0);
    chk_px("lo_s0", 1'b0, 5'h00, 5'h00, 5'h00);
    step();
    chk_px("lo_s1", 1'b0, 5'h00, 5'h00, 5'h00);
    step();
    chk_px("lo", 1'b1, 5'h1F, 5'h00, 5'h1F);
    step();
    chk_px("lo_hold", 1'b0, 5'h1F, 5'h00, 5'h1F);

    // Hi-res pair; hires/palsel changes before hpix_en must not matter
    pix_en = 1'b1; hires = 1'b1; palsel = 4'h3; vplex_in = 8'hA5;
    step();
    pix_en = 1'b0; hires = 1'b0; palsel = 4'hF; vplex_in = 8'h00;
    step();
    hpix_en = 1'b1;
    step();
    hpix_en = 1'b0;
    chk_px("hr_first", 1'b1, 5'h1F, 5'h00, 5'h00);
    step();
    chk_px("hr_gap", 1'b0, 5'h1F, 5'h00, 5'h00);
    step();
    chk_px("hr_second", 1'b1, 5'h00, 5'h1F, 5'h00);

    // Orphan hpix_en (pair already consumed, lo-res) -> no vvalid
    hpix_en = 1'b1;
    step();
    hpix_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_px("orphan", 1'b0, 5'h00, 5'h1F, 5'h00);
      step();
    end

    // Write-first bypass: write lands on the lookup clock
    strobe_lo(8'h10, 1'b0);
    cram_we = 1'b1; cram_addr = 8'h10; cram_data = 16'h03E0;
    step();
    cram_we = 1'b0;
    step();
    chk_px("bypass", 1'b1, 5'h00, 5'h1F, 5'h00);

    // Write one clock after the lookup does not affect that pixel
    strobe_lo(8'h10, 1'b0);
    step();
    wr(8'h10, 16'h001F);
    chk_px("late_wr", 1'b1, 5'h00, 5'h1F, 5'h00);
    step();
    chk_px("late_wr_hold", 1'b0, 5'h00, 5'h1F, 5'h00);
    strobe_lo(8'h10, 1'b0);
    step(); step();
    chk_px("new_data", 1'b1, 5'h00, 5'h00, 5'h1F);

    // Blanking
    strobe_lo(8'h77, 1'b1);
    step(); step();
    chk_px("blank", 1'b1, 5'h00, 5'h00, 5'h00);
    strobe_lo(8'h77, 1'b0);
    step(); step();
    chk_px("unblank", 1'b1, 5'h1F, 5'h1F, 5'h1F);

    // Back-to-back lo-res strobes
    pix_en = 1'b1; hires = 1'b0; vplex_in = 8'h5A;
    step();
    vplex_in = 8'h35;
    step();
    vplex_in = 8'h3A;
    step();
    pix_en = 1'b0;
    chk_px("b2b_0", 1'b1, 5'h1F, 5'h00, 5'h1F);
    step();
    chk_px("b2b_1", 1'b1, 5'h00, 5'h1F, 5'h00);
    step();
    chk_px("b2b_2", 1'b1, 5'h1F, 5'h00, 5'h00);
    step();
    chk_px("b2b_end", 1'b0, 5'h1F, 5'h00, 5'h00);

    // Override: second hi-res pix_en drops the first pending half (0x35)
    pix_en = 1'b1; hires = 1'b1; palsel = 4'h3; vplex_in = 8'hA5;
    step();
    vplex_in = 8'h7C;
    step();
    pix_en = 1'b0; hires = 1'b0;
    step();
    chk_px("ovr_0", 1'b1, 5'h1F, 5'h00, 5'h00);
    step();
    chk_px("ovr_1", 1'b1, 5'h00, 5'h00, 5'h01);
    step();
    chk_px("ovr_end", 1'b0, 5'h00, 5'h00, 5'h01);

    // Reset mid-pair: the pending half never appears
    pix_en = 1'b1; hires = 1'b1; palsel = 4'h3; vplex_in = 8'hA5;
    step();
    pix_en = 1'b0; hires = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    hpix_en = 1'b1;
    step();
    hpix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_px("rst_pair", 1'b0, 5'h00, 5'h00, 5'h00);
      step();
    end

    // First pix_en after reset works normally
    strobe_lo(8'h5A, 1'b0);
    step(); step();
    chk_px("post_rst", 1'b1, 5'h1F, 5'h00, 5'h1F);
    step();
    chk_px("post_rst_end", 1'b0, 5'h1F, 5'h00, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
